// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared sizing constants and loader state type for the flatten input loader
package bnn_pkg;

    localparam int NUM_INPUTS_DEF = 196;
    localparam int BYTE_W_DEF     = 8;
    localparam int NUM_BYTES_DEF  = (NUM_INPUTS_DEF + BYTE_W_DEF - 1) / BYTE_W_DEF;
    localparam int FRAME_CNT_W    = 8;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } load_state_t;

endpackage

// File: rtl/flatten_input_loader.sv
// rtl/flatten_input_loader.sv - assembles a byte stream into one feature vector per frame
// Optional: FLATTEN_LOADER_LAST_CHECK_EN adds in_last framing check and sticky frame_err.
module flatten_input_loader
    import bnn_pkg::*;
#(
    parameter int NUM_INPUTS = NUM_INPUTS_DEF,
    parameter int BYTE_W     = BYTE_W_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [BYTE_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
`ifdef FLATTEN_LOADER_LAST_CHECK_EN
    input  logic                   in_last,
    output logic                   frame_err,
`endif
    output logic [NUM_INPUTS-1:0]  data_out,
    output logic                   vec_valid,
    input  logic                   vec_ready,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int NUM_BYTES = (NUM_INPUTS + BYTE_W - 1) / BYTE_W;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    load_state_t             state_q, state_d;
    logic [IDX_W-1:0]        idx_q;
    logic [NUM_INPUTS-1:0]   data_q;
    logic [FRAME_CNT_W-1:0]  frame_cnt_q;
    logic                    accept;
    logic                    last_byte;
    logic                    frame_bad;
    logic                    handshake;

    assign last_byte = (idx_q == LAST_IDX);

`ifdef FLATTEN_LOADER_LAST_CHECK_EN
    logic frame_err_q;

    // in_last must mark exactly the final byte of a frame; any disagreement drops the frame.
    assign frame_bad = accept && (in_last != last_byte);
    assign frame_err = frame_err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_err_q <= 1'b0;
        end else if (frame_bad) begin
            frame_err_q <= 1'b1;
        end
    end
`else
    assign frame_bad = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        vec_valid = 1'b0;
        accept    = 1'b0;
        handshake = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept && last_byte && !frame_bad) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                vec_valid = 1'b1;
                handshake = vec_ready;
                if (vec_ready) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            data_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q <= (last_byte || frame_bad) ? '0 : idx_q + 1'b1;
                // Per-bit write so bits of the final byte beyond NUM_INPUTS simply have no target.
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (idx_q == IDX_W'(i / BYTE_W)) begin
                        data_q[i] <= in_data[i % BYTE_W];
                    end
                end
            end
            if (handshake) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign data_out  = data_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_flatten_input_loader.sv
// tb/tb_flatten_input_loader.sv - directed self-checking bench for flatten_input_loader
module tb_flatten_input_loader;

    logic         clock = 1'b0;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [195:0] data_out;
    logic         vec_valid;
    logic         vec_ready;
    logic [7:0]   frame_cnt;
`ifdef FLATTEN_LOADER_LAST_CHECK_EN
    logic         in_last;
    logic         frame_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0]   exp_cnt;
    logic [195:0] exp_v;

    always #5 clock = ~clock;

    flatten_input_loader #(.NUM_INPUTS(196), .BYTE_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef FLATTEN_LOADER_LAST_CHECK_EN
        .in_last   (in_last),
        .frame_err (frame_err),
`endif
        .data_out  (data_out),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .frame_cnt (frame_cnt)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [195:0] obs, input logic [195:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [195:0] frame_vec(input logic [7:0] base, input logic [7:0] last);
        logic [199:0] t;
        t = '0;
        for (int k = 0; k < 24; k++) t[8*k +: 8] = 8'(base + 8'(k));
        t[199:192] = last;
        return t[195:0];
    endfunction

    // Sends one 25-byte frame; bad_last >= 0 puts in_last on that byte instead of byte 24.
    task automatic load_bytes(input logic [7:0] base, input logic [7:0] last, input bit gap,
                              input int nbytes, input int bad_last);
        for (int k = 0; k < nbytes; k++) begin
            if (gap) begin
                while ($urandom_range(1, 0) == 1) begin
                    in_valid = 1'b0;
                    in_data  = 8'hEE;
                    tick();
                end
            end
            if (k == 24) check("no_early_valid", 196'(vec_valid), 196'(1'b0));
            in_valid = 1'b1;
            in_data  = (k == 24) ? last : 8'(base + 8'(k));
`ifdef FLATTEN_LOADER_LAST_CHECK_EN
            in_last  = (bad_last >= 0) ? (k == bad_last) : (k == 24);
`else
            if (bad_last >= 0) in_data = in_data;
`endif
            tick();
        end
        in_valid = 1'b0;
`ifdef FLATTEN_LOADER_LAST_CHECK_EN
        in_last  = 1'b0;
`endif
    endtask

    task automatic drain();
        vec_ready = 1'b1;
        tick();
        vec_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        check("drain_vec_valid", 196'(vec_valid), 196'(1'b0));
        check("drain_in_ready", 196'(in_ready), 196'(1'b1));
        check("drain_frame_cnt", 196'(frame_cnt), 196'(exp_cnt));
    endtask

    initial begin
        reset = 1'b1; in_data = '0; in_valid = 1'b0; vec_ready = 1'b0;
`ifdef FLATTEN_LOADER_LAST_CHECK_EN
        in_last = 1'b0;
`endif
        exp_cnt = 8'd0;
        tick(); tick();
        reset = 1'b0;
        check("rst_in_ready", 196'(in_ready), 196'(1'b1));
        check("rst_vec_valid", 196'(vec_valid), 196'(1'b0));
        check("rst_data_out", data_out, 196'd0);
        check("rst_frame_cnt", 196'(frame_cnt), 196'd0);

        // Reset after 12 bytes discards the partial frame.
        load_bytes(8'h30, 8'h00, 1'b0, 12, -1);
        check("mid_data_nonzero", 196'(data_out[15:8]), 196'h31);
        reset = 1'b1; tick(); reset = 1'b0;
        check("midrst_data_out", data_out, 196'd0);
        check("midrst_frame_cnt", 196'(frame_cnt), 196'd0);
        check("midrst_in_ready", 196'(in_ready), 196'(1'b1));

        // Clean frame 0x00..0x18, zero latency to vec_valid.
        load_bytes(8'h00, 8'h18, 1'b0, 25, -1);
        check("f1_vec_valid", 196'(vec_valid), 196'(1'b1));
        check("f1_in_ready", 196'(in_ready), 196'(1'b0));
        check("f1_byte0", 196'(data_out[7:0]), 196'h00);
        check("f1_byte1", 196'(data_out[15:8]), 196'h01);
        check("f1_top", 196'(data_out[195:192]), 196'h8);
        check("f1_vec", data_out, frame_vec(8'h00, 8'h18));
        drain();

        // Byte 24 = 0xFF, held in FULL for 10 cycles with ignored traffic.
        load_bytes(8'h80, 8'hFF, 1'b0, 25, -1);
        exp_v = frame_vec(8'h80, 8'hFF);
        check("f2_top", 196'(data_out[195:192]), 196'hF);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
            tick();
            check("hold_vec_valid", 196'(vec_valid), 196'(1'b1));
            check("hold_in_ready", 196'(in_ready), 196'(1'b0));
            check("hold_data", data_out, exp_v);
            check("hold_frame_cnt", 196'(frame_cnt), 196'(exp_cnt));
        end
        in_valid = 1'b0;
        drain();
        check("retain_after_hs", data_out, exp_v);

        // vec_ready while idle in LOAD has no effect.
        vec_ready = 1'b1;
        tick(); tick(); tick();
        vec_ready = 1'b0;
        check("idle_ready_cnt", 196'(frame_cnt), 196'(exp_cnt));
        check("idle_ready_in_ready", 196'(in_ready), 196'(1'b1));

        // Randomly gapped frame must match the gap-free result.
        load_bytes(8'h40, 8'h5C, 1'b1, 25, -1);
        check("gap_vec_valid", 196'(vec_valid), 196'(1'b1));
        check("gap_vec", data_out, frame_vec(8'h40, 8'h5C));
        check("gap_top", 196'(data_out[195:192]), 196'hC);

        // Reset wins over a same-cycle handshake in FULL.
        vec_ready = 1'b1; reset = 1'b1;
        tick();
        vec_ready = 1'b0; reset = 1'b0;
        exp_cnt = 8'd0;
        check("fullrst_frame_cnt", 196'(frame_cnt), 196'd0);
        check("fullrst_vec_valid", 196'(vec_valid), 196'(1'b0));
        check("fullrst_data", data_out, 196'd0);

        // 256 frames wrap frame_cnt back to zero.
        for (int f = 0; f < 256; f++) begin
            load_bytes(8'(f), 8'(255 - f), 1'b0, 25, -1);
            if (f == 255) check("last_frame_vec", data_out, frame_vec(8'hFF, 8'h00));
            drain();
            if (f == 254) check("cnt_255", 196'(frame_cnt), 196'hFF);
        end
        check("cnt_wrap", 196'(frame_cnt), 196'd0);

`ifdef FLATTEN_LOADER_LAST_CHECK_EN
        check("err_clear", 196'(frame_err), 196'(1'b0));
        load_bytes(8'h20, 8'h00, 1'b0, 11, 10);
        tick();
        check("err_set", 196'(frame_err), 196'(1'b1));
        check("err_no_valid", 196'(vec_valid), 196'(1'b0));
        load_bytes(8'h60, 8'h7A, 1'b0, 25, -1);
        check("err_next_valid", 196'(vec_valid), 196'(1'b1));
        check("err_next_vec", data_out, frame_vec(8'h60, 8'h7A));
        check("err_sticky", 196'(frame_err), 196'(1'b1));
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
